jk_excitation_driver: RTL

- Synthesizable driver for a bank of N master-slave JK flip-flops.
- Accepts target-state commands over a valid/ready handshake and converts each one into J/K excitation for one clock cycle.
- After a settle window it reads the flops' Q feedback, compares it with the expected state and reports pass or fail.
- Sits upstream of the JK flop bank, replacing hand-written J/K stimulus with a checked command stream.

---
 rtl/jk_drv_pkg.sv | 18 +
 rtl/jk_drv_excite_bit.sv | 32 +++
 rtl/jk_excitation_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/jk_drv_pkg.sv
// Shared encodings for the JK excitation driver: command modes and FSM states.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_CLRERR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_CHECK  = 2'd3
  } state_e;

endpackage

// File: rtl/jk_drv_excite_bit.sv
// Per-bit J/K excitation generator: maps (current q, target t, mode) to J, K and the expected next q.
module jk_excite_bit
  import jk_drv_pkg::*;
(
  input  logic  q,
  input  logic  t,
  input  mode_e mode,
  output logic  j,
  output logic  k,
  output logic  e
);

  always_comb begin
    j = 1'b0;
    k = 1'b0;
    e = q;
    case (mode)
      MODE_LOAD: begin
        j = ~q & t;
        k = q & ~t;
        e = t;
      end
      MODE_TOGGLE: begin
        j = 1'b1;
        k = 1'b1;
        e = ~q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Command-driven J/K excitation driver with settle window and Q feedback check.
// Optional sticky error halt enabled by defining JK_DRV_STICKY_ERR_EN.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [N-1:0]     in_target,
  output logic [N-1:0]     j_out,
  output logic [N-1:0]     k_out,
  input  logic [N-1:0]     q_fb,
  output logic             out_valid,
  output logic             out_match,
  output logic [N-1:0]     expected,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sticky
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     j_q, j_d, k_q, k_d, exp_q, exp_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ready_q, ready_d;
  logic             ovalid_q, ovalid_d;
  logic             sticky_q, sticky_d;

  mode_e            mode_in;
  logic [N-1:0]     j_c, k_c, e_c;
  logic             accept;

  assign mode_in = mode_e'(in_mode);

  // Excitation is derived from q_fb at the accepting edge, so j/k/expected capture the q snapshot.
  for (genvar i = 0; i < int'(N); i++) begin : g_bit
    jk_excite_bit u_bit (
      .q    (q_fb[i]),
      .t    (in_target[i]),
      .mode (mode_in),
      .j    (j_c[i]),
      .k    (k_c[i]),
      .e    (e_c[i])
    );
  end

`ifdef JK_DRV_STICKY_ERR_EN
  assign in_ready   = ready_q & (~sticky_q | (in_valid & (mode_in == MODE_CLRERR)));
  assign err_sticky = sticky_q;
`else
  assign in_ready   = ready_q;
  assign err_sticky = 1'b0;
`endif

  assign accept    = in_valid & in_ready;
  assign j_out     = j_q;
  assign k_out     = k_q;
  assign expected  = exp_q;
  assign err_count = err_q;
  assign out_valid = ovalid_q;
  assign out_match = ovalid_q & (q_fb == exp_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    j_d      = '0;
    k_d      = '0;
    exp_d    = exp_q;
    err_d    = err_q;
    ovalid_d = 1'b0;
    sticky_d = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (mode_in == MODE_CLRERR) begin
            err_d    = '0;
            sticky_d = 1'b0;
          end else begin
            state_d = S_DRIVE;
            j_d     = j_c;
            k_d     = k_c;
            exp_d   = e_c;
          end
        end
      end
      S_DRIVE: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = S_CHECK;
          cnt_d    = '0;
          ovalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (q_fb != exp_q) begin
          sticky_d = 1'b1;
          if (err_q != '1) err_d = err_q + ERR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      exp_q    <= '0;
      err_q    <= '0;
      ready_q  <= 1'b1;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      ovalid_q <= ovalid_d;
    end
  end

`ifdef JK_DRV_STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end
`else
  assign sticky_q = 1'b0;
`endif

endmodule
